mult_add_acc: RTL and testbench

- Parametrised, vendor-neutral successor to the DSP48 multiply-add: signed P = A*B + C on AXI-stream, with three additions.
- A per-packet accumulate mode.
- Output rounding and saturation with a saturation flag.
- Full-pipeline backpressure.
- Sits in RFNoC compute blocks (FIR taps, correlators, dot products) between AXI-stream sources and a downstream sink.

---
 rtl/mult_add_acc_pkg.sv | 35 +++
 rtl/mult_add_acc_round_sat.sv | 35 +++
 rtl/mult_add_acc.sv | 194 +++++++++++++++++++
 tb/tb_mult_add_acc.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_add_acc_pkg.sv
// mult_add_acc_pkg: shared constants, rounding/saturation helpers and parameter checks
package mult_add_acc_pkg;

    localparam int LATENCY_MIN = 3;
    localparam int LATENCY_MAX = 4;

    // Half-LSB bias added before the arithmetic shift; zero when nothing is dropped
    function automatic longint round_const(input int drop);
        return (drop > 0) ? (longint'(1) << (drop - 1)) : longint'(0);
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) << (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) << (width - 1));
    endfunction

    function automatic bit params_ok(
        input int wa,
        input int wb,
        input int wc,
        input int wacc,
        input int drop,
        input int wp,
        input int lat
    );
        return (wa >= 2) && (wa <= 27) && (wb >= 2) && (wb <= 27) &&
               (wc >= 1) && (wc <= wacc) && (wacc >= wa + wb) &&
               (drop >= 0) && (wp >= 2) && (wp <= wacc - drop) &&
               ((lat == LATENCY_MIN) || (lat == LATENCY_MAX));
    endfunction

endpackage

// File: rtl/mult_add_acc_round_sat.sv
// round_sat: round-half-up by DROP_BOTTOM bits, then clamp to a signed WIDTH_P range
module round_sat
    import mult_add_acc_pkg::*;
#(
    parameter int WIDTH_IN    = 48,
    parameter int DROP_BOTTOM = 15,
    parameter int WIDTH_P     = 16
) (
    input  logic signed [WIDTH_IN-1:0] din,
    output logic signed [WIDTH_P-1:0]  dout,
    output logic                       sat
);

    localparam int XW = WIDTH_IN + 1;
    localparam int SW = XW - DROP_BOTTOM;
    localparam logic signed [XW-1:0] RC    = XW'(round_const(DROP_BOTTOM));
    localparam logic signed [SW-1:0] MAX_V = SW'(sat_max(WIDTH_P));
    localparam logic signed [SW-1:0] MIN_V = SW'(sat_min(WIDTH_P));

    logic signed [XW-1:0] biased;
    logic signed [SW-1:0] shifted;
    logic                 hi;
    logic                 lo;

    // One guard bit keeps the half-LSB bias from wrapping at the top of the input range
    always_comb begin
        biased  = {din[WIDTH_IN-1], din} + RC;
        shifted = biased[XW-1:DROP_BOTTOM];
        hi      = shifted > MAX_V;
        lo      = shifted < MIN_V;
        sat     = hi | lo;
        dout    = hi ? MAX_V[WIDTH_P-1:0] : lo ? MIN_V[WIDTH_P-1:0] : shifted[WIDTH_P-1:0];
    end

endmodule

// File: rtl/mult_add_acc.sv
// mult_add_acc: AXI-stream signed P = A*B + C with per-packet accumulate, rounding and saturation
module mult_add_acc
    import mult_add_acc_pkg::*;
#(
    parameter int WIDTH_A     = 16,
    parameter int WIDTH_B     = 16,
    parameter int WIDTH_C     = 32,
    parameter int WIDTH_ACC   = 48,
    parameter int DROP_BOTTOM = 15,
    parameter int WIDTH_P     = 16,
    parameter int LATENCY     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               acc_en,
    input  logic [WIDTH_A-1:0] a_tdata,
    input  logic               a_tlast,
    input  logic               a_tvalid,
    output logic               a_tready,
    input  logic [WIDTH_B-1:0] b_tdata,
    input  logic               b_tlast,
    input  logic               b_tvalid,
    output logic               b_tready,
    input  logic [WIDTH_C-1:0] c_tdata,
    input  logic               c_tlast,
    input  logic               c_tvalid,
    output logic               c_tready,
    output logic [WIDTH_P-1:0] p_tdata,
    output logic               p_tuser,
    output logic               p_tlast,
    output logic               p_tvalid,
    input  logic               p_tready
);

    localparam int WIDTH_M = WIDTH_A + WIDTH_B;

    if (!params_ok(WIDTH_A, WIDTH_B, WIDTH_C, WIDTH_ACC, DROP_BOTTOM, WIDTH_P, LATENCY)) begin : g_bad_params
        $error("mult_add_acc: illegal parameter combination");
    end

    logic unused_tlast;
    assign unused_tlast = &{1'b0, b_tlast, c_tlast};

    logic advance;
    logic accept;
    logic first;
    logic pkt_mode;
    logic beat_mode;

    // Every stage moves together; the join only fires when all three streams offer a beat
    assign advance   = ~p_tvalid | p_tready;
    assign accept    = advance & a_tvalid & b_tvalid & c_tvalid;
    assign a_tready  = accept;
    assign b_tready  = accept;
    assign c_tready  = accept;
    assign beat_mode = first ? acc_en : pkt_mode;

    // Packet framing: a_tlast re-arms the first-beat flag, acc_en is frozen on the first beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first    <= 1'b1;
            pkt_mode <= 1'b0;
        end else if (accept) begin
            first <= a_tlast;
            if (first)
                pkt_mode <= acc_en;
        end
    end

    logic                      s0_valid;
    logic signed [WIDTH_A-1:0] s0_a;
    logic signed [WIDTH_B-1:0] s0_b;
    logic signed [WIDTH_C-1:0] s0_c;
    logic                      s0_last;
    logic                      s0_first;
    logic                      s0_mode;

    if (LATENCY == LATENCY_MAX) begin : g_s0
        // Optional input register stage for the 4-cycle build
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s0_valid <= 1'b0;
                s0_a     <= '0;
                s0_b     <= '0;
                s0_c     <= '0;
                s0_last  <= 1'b0;
                s0_first <= 1'b0;
                s0_mode  <= 1'b0;
            end else if (advance) begin
                s0_valid <= accept;
                s0_a     <= a_tdata;
                s0_b     <= b_tdata;
                s0_c     <= c_tdata;
                s0_last  <= a_tlast;
                s0_first <= first;
                s0_mode  <= beat_mode;
            end
        end
    end else begin : g_no_s0
        // Without the input register the beat feeds the multiplier directly
        always_comb begin
            s0_valid = accept;
            s0_a     = a_tdata;
            s0_b     = b_tdata;
            s0_c     = c_tdata;
            s0_last  = a_tlast;
            s0_first = first;
            s0_mode  = beat_mode;
        end
    end

    logic                      s1_valid;
    logic signed [WIDTH_M-1:0] s1_m;
    logic signed [WIDTH_C-1:0] s1_c;
    logic                      s1_last;
    logic                      s1_first;
    logic                      s1_mode;

    // S1: full-precision signed product, addend carried alongside
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_m     <= '0;
            s1_c     <= '0;
            s1_last  <= 1'b0;
            s1_first <= 1'b0;
            s1_mode  <= 1'b0;
        end else if (advance) begin
            s1_valid <= s0_valid;
            s1_m     <= WIDTH_M'(s0_a) * WIDTH_M'(s0_b);
            s1_c     <= s0_c;
            s1_last  <= s0_last;
            s1_first <= s0_first;
            s1_mode  <= s0_mode;
        end
    end

    logic signed [WIDTH_ACC-1:0] m_ext;
    logic signed [WIDTH_ACC-1:0] c_ext;
    logic signed [WIDTH_ACC-1:0] acc;
    logic signed [WIDTH_ACC-1:0] acc_next;
    logic                        s2_valid;
    logic                        s2_last;

    assign m_ext    = WIDTH_ACC'(s1_m);
    assign c_ext    = WIDTH_ACC'(s1_c);
    assign acc_next = (s1_mode & ~s1_first) ? acc + m_ext : c_ext + m_ext;

    // S2: one register serves as both the plain M+C result and the running packet sum;
    // in accumulate mode only the tlast beat is passed on to the output stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid & (~s1_mode | s1_last);
            s2_last  <= s1_last | s1_mode;
            if (s1_valid)
                acc <= acc_next;
        end
    end

    logic signed [WIDTH_P-1:0] rs_data;
    logic                      rs_sat;

    round_sat #(
        .WIDTH_IN   (WIDTH_ACC),
        .DROP_BOTTOM(DROP_BOTTOM),
        .WIDTH_P    (WIDTH_P)
    ) u_round_sat (
        .din (acc),
        .dout(rs_data),
        .sat (rs_sat)
    );

    // S3: output register; payload only changes when a real result arrives
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_tvalid <= 1'b0;
            p_tdata  <= '0;
            p_tuser  <= 1'b0;
            p_tlast  <= 1'b0;
        end else if (advance) begin
            p_tvalid <= s2_valid;
            if (s2_valid) begin
                p_tdata <= rs_data;
                p_tuser <= rs_sat;
                p_tlast <= s2_last;
            end
        end
    end

endmodule

// File: tb/tb_mult_add_acc.sv
// tb_mult_add_acc: randomized self-checking bench for mult_add_acc against a packet-level model
module tb_mult_add_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        acc_en;
    logic [15:0] a_tdata;
    logic [15:0] b_tdata;
    logic [31:0] c_tdata;
    logic        a_tlast, b_tlast, c_tlast;
    logic        a_tvalid, b_tvalid, c_tvalid;
    logic        a_tready, b_tready, c_tready;
    logic [15:0] p_tdata;
    logic        p_tuser, p_tlast, p_tvalid;
    logic        p_tready;
    logic        a4_tready, b4_tready, c4_tready;
    logic [15:0] p4_tdata;
    logic        p4_tuser, p4_tlast, p4_tvalid;

    mult_add_acc u_dut (
        .clk(clk), .reset(reset), .acc_en(acc_en),
        .a_tdata(a_tdata), .a_tlast(a_tlast), .a_tvalid(a_tvalid), .a_tready(a_tready),
        .b_tdata(b_tdata), .b_tlast(b_tlast), .b_tvalid(b_tvalid), .b_tready(b_tready),
        .c_tdata(c_tdata), .c_tlast(c_tlast), .c_tvalid(c_tvalid), .c_tready(c_tready),
        .p_tdata(p_tdata), .p_tuser(p_tuser), .p_tlast(p_tlast), .p_tvalid(p_tvalid),
        .p_tready(p_tready)
    );

    mult_add_acc #(.LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset), .acc_en(acc_en),
        .a_tdata(a_tdata), .a_tlast(a_tlast), .a_tvalid(a_tvalid), .a_tready(a4_tready),
        .b_tdata(b_tdata), .b_tlast(b_tlast), .b_tvalid(b_tvalid), .b_tready(b4_tready),
        .c_tdata(c_tdata), .c_tlast(c_tlast), .c_tvalid(c_tvalid), .c_tready(c4_tready),
        .p_tdata(p4_tdata), .p_tuser(p4_tuser), .p_tlast(p4_tlast), .p_tvalid(p4_tvalid),
        .p_tready(1'b1)
    );

    typedef struct {
        longint data;
        logic   user;
        logic   last;
    } exp_t;

    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    int     n_acc = 0;
    int     n_out = 0;
    bit     bp_en = 1'b0;
    bit     m_first = 1'b1;
    bit     m_mode = 1'b0;
    longint m_acc = 0;
    bit     stalled = 1'b0;
    logic [15:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrap48(input longint x);
        logic signed [47:0] t;
        t = x[47:0];
        return longint'(t);
    endfunction

    // Exact-integer round-half-up then clamp to 16-bit signed
    function automatic exp_t rs_model(input longint r);
        exp_t   e;
        longint y;
        y = (r + 64'sd16384) >>> 15;
        e.user = (y > 32767) || (y < -32768);
        e.data = (y > 32767) ? 64'sd32767 : (y < -32768) ? -64'sd32768 : y;
        e.last = 1'b0;
        return e;
    endfunction

    function automatic void model_accept(input longint a, input longint b, input longint c, input bit last, input bit en);
        exp_t e;
        bit   mode;
        mode = m_first ? en : m_mode;
        if (m_first)
            m_mode = en;
        if (!mode) begin
            e = rs_model(wrap48(c + a * b));
            e.last = last;
            exp_q.push_back(e);
        end else begin
            m_acc = m_first ? wrap48(c + a * b) : wrap48(m_acc + a * b);
            if (last) begin
                e = rs_model(m_acc);
                e.last = 1'b1;
                exp_q.push_back(e);
            end
        end
        m_first = last;
    endfunction

    // Observe both handshakes between edges, where every signal is settled
    always @(negedge clk) begin
        if (!reset) begin
            stalled = 1'b0;
        end else begin
            if (a_tready) begin
                model_accept(longint'($signed(a_tdata)), longint'($signed(b_tdata)),
                             longint'($signed(c_tdata)), a_tlast, acc_en);
                n_acc++;
            end
            if (stalled) begin
                check("stall_valid", p_tvalid, 1);
                check("stall_data", p_tdata, held);
            end
            stalled = p_tvalid && !p_tready;
            held    = p_tdata;
            if (p_tvalid && p_tready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("spurious_out", p_tvalid, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("p_tdata", $signed(p_tdata), e.data);
                    check("p_tuser", p_tuser, e.user);
                    check("p_tlast", p_tlast, e.last);
                end
            end
        end
    end

    initial begin
        p_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            p_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        c_tvalid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] c, input bit last, input bit en);
        int t;
        t = 0;
        a_tdata  = a;
        b_tdata  = b;
        c_tdata  = c;
        a_tlast  = last;
        b_tlast  = 1'($urandom);
        c_tlast  = 1'($urandom);
        acc_en   = en;
        a_tvalid = 1'b1;
        b_tvalid = 1'b1;
        c_tvalid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!a_tready && t < 200);
        if (!a_tready)
            check("send_timeout", a_tready, 1);
        acc_cyc = cyc;
        tick();
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle(0);
        while ((exp_q.size() != 0 || p_tvalid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, p_tvalid, 0);
        check({tag, "_data"}, p_tdata, 0);
        check({tag, "_user"}, p_tuser, 0);
        check({tag, "_last"}, p_tlast, 0);
        check({tag, "_valid4"}, p4_tvalid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c3, c4, n_seen, f_cyc, l_cyc, n0, a0;
        reset = 1'b0;
        acc_en = 1'b0;
        a_tdata = '0; b_tdata = '0; c_tdata = '0;
        a_tlast = 1'b0; b_tlast = 1'b0; c_tlast = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        tick();
        reset = 1'b1;
        tick();

        // Single beat: latency of both builds
        send(16'd16384, 16'd16384, 32'd0, 1'b1, 1'b0);
        idle(0);
        c3 = -1;
        c4 = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (p_tvalid && c3 < 0) c3 = cyc;
            if (p4_tvalid && c4 < 0) c4 = cyc;
        end
        check("latency3", c3 - acc_cyc, 3);
        check("latency4", c4 - acc_cyc, 4);
        check("latency4_data", $signed(p4_tdata), 8192);
        tick();

        // Back-to-back beats come out one per cycle
        n_seen = 0;
        f_cyc = -1;
        l_cyc = -1;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(16'd16384, 16'd16384, 32'd0, 1'b1, 1'b0);
                idle(0);
            end
            begin
                for (int i = 0; i < 14; i++) begin
                    @(negedge clk);
                    if (p_tvalid) begin
                        n_seen++;
                        if (f_cyc < 0) f_cyc = cyc;
                        l_cyc = cyc;
                    end
                end
            end
        join
        check("burst_count", n_seen, 4);
        check("burst_span", l_cyc - f_cyc, 3);
        drain();

        // Saturation and half-up rounding
        send(16'h8000, 16'h8000, 32'd0, 1'b1, 1'b0);
        send(16'd1, 16'd1, 32'd16384, 1'b1, 1'b0);
        drain();

        // Accumulated packet: one saturated output, none for the inner beats
        n0 = n_out;
        send(16'd8192, 16'd16384, 32'd32768, 1'b0, 1'b1);
        send(16'd16384, 16'd16384, $urandom, 1'b0, 1'b0);
        send(16'd24576, 16'd16384, $urandom, 1'b0, 1'b1);
        send(16'd24576, 16'd16384, $urandom, 1'b1, 1'b0);
        drain();
        check("pkt_outputs", n_out - n0, 1);

        // Join: without A nothing is consumed from B or C
        n0 = n_out;
        a0 = n_acc;
        a_tvalid = 1'b0;
        b_tvalid = 1'b1;
        c_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("join_ready", {a_tready, b_tready, c_tready}, 0);
        end
        tick();
        send(16'd300, 16'hFF00, 32'd5, 1'b1, 1'b0);
        drain();
        check("join_accepts", n_acc - a0, 1);
        check("join_outputs", n_out - n0, 1);

        // Random packets in both modes under random backpressure
        bp_en = 1'b1;
        a0 = n_acc;
        while (n_acc - a0 < 200) begin
            int len;
            bit en;
            len = $urandom_range(1, 5);
            en  = 1'($urandom);
            for (int i = 0; i < len; i++) begin
                send(16'($urandom), 16'($urandom), $urandom, i == len - 1,
                     (i == 0) ? en : 1'($urandom));
                if ($urandom_range(0, 3) == 0)
                    idle($urandom_range(1, 3));
            end
        end
        drain();
        bp_en = 1'b0;
        tick();

        // Reset in the middle of an accumulated packet leaves nothing behind
        send(16'd20000, 16'd20000, 32'd123456, 1'b0, 1'b1);
        send(16'd20000, 16'd20000, 32'd0, 1'b0, 1'b1);
        idle(1);
        reset = 1'b0;
        exp_q.delete();
        m_first = 1'b1;
        m_mode  = 1'b0;
        m_acc   = 0;
        check_reset_outputs("midreset");
        tick();
        reset = 1'b1;
        tick();
        n0 = n_out;
        send(16'd0, 16'd0, 32'd0, 1'b1, 1'b1);
        drain();
        check("post_reset_outputs", n_out - n0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
